// File: rtl/dff_bank_arbiter_pkg.sv
// Shared types and defaults for the two-requester register-bank arbiter.
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    CLEAR  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_TIMEOUT = 15;

  function automatic logic is_grant(arb_state_e s);
    return (s == GRANT0) || (s == GRANT1);
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_reg_sync_clear.sv
// WIDTH-bit data register with synchronous clear (priority over load) and async active-low reset.
module reg_sync_clear #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter granting one of two writers ownership of a shared register.
// Optional grant-length limit with error pulse is enabled by defining DFF_ARB_TIMEOUT_EN.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic             clr_req_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             clr_done_o,
  output logic             err_o
);

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             at_limit;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear wins over everything; a release or timeout hands priority to the other side.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    load_en   = 1'b0;
    load_data = d0_i;
    if (clr_req_i) begin
      state_d = CLEAR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_i && req1_i) state_d = ptr_q ? GRANT1 : GRANT0;
          else if (req0_i)      state_d = GRANT0;
          else if (req1_i)      state_d = GRANT1;
        end
        GRANT0: begin
          if (req0_i) begin
            load_en   = 1'b1;
            load_data = d0_i;
            if (at_limit) begin
              state_d = IDLE;
              ptr_d   = 1'b1;
            end
          end else begin
            state_d = IDLE;
            ptr_d   = 1'b1;
          end
        end
        GRANT1: begin
          if (req1_i) begin
            load_en   = 1'b1;
            load_data = d1_i;
            if (at_limit) begin
              state_d = IDLE;
              ptr_d   = 1'b0;
            end
          end else begin
            state_d = IDLE;
            ptr_d   = 1'b0;
          end
        end
        CLEAR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign at_limit = is_grant(state_q) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Counter restarts on every fresh grant, so it only tracks the current tenure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= at_limit && !clr_req_i &&
               (((state_q == GRANT0) && req0_i) || ((state_q == GRANT1) && req1_i));
      if (is_grant(state_q) && (state_d == state_q)) cnt_q <= cnt_q + 1'b1;
      else                                          cnt_q <= '0;
    end
  end

  assign err_o = err_q;
`else
  assign at_limit = 1'b0;
  assign err_o    = 1'b0;
`endif

  reg_sync_clear #(
    .WIDTH(WIDTH)
  ) u_shared_reg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr_req_i),
    .en_i  (load_en),
    .d_i   (load_data),
    .q_o   (q_o)
  );

  assign gnt0_o     = (state_q == GRANT0);
  assign gnt1_o     = (state_q == GRANT1);
  assign busy_o     = (state_q != IDLE);
  assign clr_done_o = (state_q == CLEAR);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter against an ownership-based reference model.
// Honours DFF_ARB_TIMEOUT_EN the same way as the design build.
module tb_dff_bank_arbiter;

  localparam int WIDTH = 8;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             rstN;
  logic             req0, req1, clrReq;
  logic [WIDTH-1:0] d0, d1;
  logic             gnt0, gnt1, busy, clrDone, err;
  logic [WIDTH-1:0] q;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // Reference model: who owns the register, whether a clear is being acknowledged.
  int               owner;
  int               ptr;
  int               held;
  logic             clearing;
  logic             errExp;
  logic [WIDTH-1:0] qExp;

  wire [WIDTH+4:0] obsVec = {gnt0, gnt1, busy, clrDone, err, q};

  dff_bank_arbiter #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .req0_i    (req0),
    .req1_i    (req1),
    .d0_i      (d0),
    .d1_i      (d1),
    .clr_req_i (clrReq),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .q_o       (q),
    .busy_o    (busy),
    .clr_done_o(clrDone),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH+4:0] expVec();
    return {owner == 0, owner == 1, (owner >= 0) || clearing, clearing, errExp, qExp};
  endfunction

  task automatic modelReset();
    owner    = -1;
    ptr      = 0;
    held     = 0;
    clearing = 1'b0;
    errExp   = 1'b0;
    qExp     = '0;
  endtask

  task automatic modelStep();
    logic ownReq;
    errExp = 1'b0;
    if (clrReq) begin
      qExp     = '0;
      owner    = -1;
      clearing = 1'b1;
    end else if (clearing) begin
      clearing = 1'b0;
    end else if (owner < 0) begin
      held = 0;
      if (req0 && req1) owner = ptr;
      else if (req0)    owner = 0;
      else if (req1)    owner = 1;
    end else begin
      ownReq = (owner == 0) ? req0 : req1;
      if (ownReq) begin
        qExp = (owner == 0) ? d0 : d1;
        held++;
`ifdef DFF_ARB_TIMEOUT_EN
        if (held == TMO) begin
          ptr    = 1 - owner;
          owner  = -1;
          errExp = 1'b1;
        end
`endif
      end else begin
        ptr   = 1 - owner;
        owner = -1;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    clrReq = 1'b0;
    #2;
    modelReset();
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    req0 = 1'b0; req1 = 1'b0; clrReq = 1'b0;
    d0 = 8'h5A; d1 = 8'hC3;
    modelReset();
    #2;
    checks++;
    if (obsVec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_early got=%h expected=%h", obsVec, {(WIDTH+5){1'b0}});
    end
    #8;
    checks++;
    if (obsVec !== '0) begin
      errors++;
      $display("[TB] FAIL reset_held got=%h expected=%h", obsVec, {(WIDTH+5){1'b0}});
    end
    #2;
    rstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obsVec !== expVec() || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
    end
  endtask

  task automatic test_single_burst();
    req0 = 1'b1;
    d0   = 8'hA5;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL burst_model cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
      if (i == 1) begin
        checks++;
        if (gnt0 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL burst_gnt0_rise got=%b expected=1", gnt0);
        end
      end
      if (i == 2) begin
        checks++;
        if (q !== 8'hA5) begin
          errors++;
          $display("[TB] FAIL burst_q_load got=%h expected=a5", q);
        end
      end
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b0 || q !== 8'hA5 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL burst_release got=%h expected=%h", obsVec, expVec());
    end
  endtask

  task automatic test_round_robin();
    logic sawGnt1;
    doReset();
    req0 = 1'b1; req1 = 1'b1;
    d0 = 8'h11; d1 = 8'h22;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL rr_first_gnt0 got=%h expected=%h", obsVec, expVec());
    end
    for (int i = 0; i < 2; i++) begin
      d0 = WIDTH'($urandom);
      tick();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL rr_hold0 cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
    end
    req0 = 1'b0;
    sawGnt1 = 1'b0;
    for (int i = 0; i < 2 && !sawGnt1; i++) begin
      tick();
      sawGnt1 = gnt1;
    end
    checks++;
    if (sawGnt1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rr_gnt1_within_2 got=%b expected=1", sawGnt1);
    end
    for (int i = 0; i < 3; i++) begin
      d1 = WIDTH'($urandom);
      tick();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL rr_q_follows_d1 cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
    end
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    doReset();
    req1 = 1'b1;
    d1   = 8'h3C;
    tick();
    tick();
    checks++;
    if (q !== 8'h3C || gnt1 !== 1'b1 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL clear_setup got=%h expected=%h", obsVec, expVec());
    end
    clrReq = 1'b1;
    req1   = 1'b0;
    tick();
    checks++;
    if (q !== 8'h00 || gnt1 !== 1'b0 || clrDone !== 1'b1 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL clear_edge got=%h expected=%h", obsVec, expVec());
    end
    clrReq = 1'b0;
    tick();
    checks++;
    if (clrDone !== 1'b0 || busy !== 1'b0 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL clear_to_idle got=%h expected=%h", obsVec, expVec());
    end
  endtask

  task automatic test_timeout();
    int   gnt0Cycles;
    int   errPulses;
    logic errPrev;
`ifdef DFF_ARB_TIMEOUT_EN
    localparam int EXP_GNT0 = TMO;
    localparam int EXP_ERR  = 1;
`else
    localparam int EXP_GNT0 = 20;
    localparam int EXP_ERR  = 0;
`endif
    doReset();
    gnt0Cycles = 0;
    errPulses  = 0;
    errPrev    = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d0 = WIDTH'($urandom);
      d1 = WIDTH'($urandom);
      tick();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL timeout_model cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
      if (errPrev) begin
        checks++;
        if (gnt1 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL timeout_gnt1_next got=%b expected=1", gnt1);
        end
      end
      if (gnt0) gnt0Cycles++;
      if (err)  errPulses++;
      errPrev = err;
    end
    checks++;
    if (gnt0Cycles != EXP_GNT0) begin
      errors++;
      $display("[TB] FAIL timeout_gnt0_len got=%0d expected=%0d", gnt0Cycles, EXP_GNT0);
    end
    checks++;
    if (errPulses != EXP_ERR) begin
      errors++;
      $display("[TB] FAIL timeout_err_pulses got=%0d expected=%0d", errPulses, EXP_ERR);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    doReset();
    req0 = 1'b1;
    d0   = 8'h77;
    tick(); tick();
    req0 = 1'b0;
    tick();
    req0 = 1'b1;
    d0   = 8'h9E;
    tick(); tick(); tick();
    checks++;
    if (obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL arst_setup got=%h expected=%h", obsVec, expVec());
    end
    #3;
    rstN = 1'b0;
    #1;
    checks++;
    if (q !== '0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_immediate got=%h expected=%h", obsVec, {(WIDTH+5){1'b0}});
    end
    modelReset();
    req1 = 1'b1;
    #1;
    rstN = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || obsVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL arst_ptr_zero got=%h expected=%h", obsVec, expVec());
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      clrReq = ($urandom_range(0, 15) == 0);
      d0 = WIDTH'($urandom);
      d1 = WIDTH'($urandom);
      tick();
      checks++;
      if (obsVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cycle=%0d got=%h expected=%h", cycleNo, obsVec, expVec());
      end
    end
    req0 = 1'b0; req1 = 1'b0; clrReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle=%0d", cycleNo);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_clear();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
